// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
//  chunk_adder
//  Multi-cycle adder/subtractor: CHUNK bits per cycle with a rippled carry.
//  Rev 1.0
// ============================================================================
module chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] C_LAST = IW'(NCH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   generate
      if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [IW-1:0]    r_idx;

   logic [CHUNK-1:0] w_a_ch;
   logic [CHUNK-1:0] w_b_ch;
   logic [CHUNK:0]   w_ch_sum;
   logic             w_ovf;

   assign w_a_ch   = r_a[r_idx*CHUNK +: CHUNK];
   assign w_b_ch   = r_b[r_idx*CHUNK +: CHUNK];
   assign w_ch_sum = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
   // Carry into the MSB is recovered from the MSB sum bit; only valid on the last chunk.
   assign w_ovf    = (w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1] ^ w_ch_sum[CHUNK-1]) ^ w_ch_sum[CHUNK];

   assign in_ready = (r_state == S_IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_carry   <= 1'b0;
         r_idx     <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= c_in ^ sub;
                  r_idx   <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               sum[r_idx*CHUNK +: CHUNK] <= w_ch_sum[CHUNK-1:0];
               r_carry <= w_ch_sum[CHUNK];
               if (r_idx == C_LAST) begin
                  c_out     <= w_ch_sum[CHUNK];
                  ovf       <= w_ovf;
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_chunk_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_chunk_adder
//  Self-checking bench: 8-bit/2-bit-chunk and 3-bit/1-bit-chunk instances.
//  Rev 1.0
// ============================================================================
module tb_chunk_adder;
   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       v;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       c;
      logic       v;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic       iv8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0, or8 = 1'b1;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ir8, ov8, co8, of8;
   logic [7:0] s8;

   logic       iv3 = 1'b0, sub3 = 1'b0, cin3 = 1'b0, or3 = 1'b1;
   logic [2:0] a3 = '0, b3 = '0;
   logic       ir3, ov3, co3, of3;
   logic [2:0] s3;

   chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .c_in(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
      .c_out(co8), .ovf(of8)
   );

   chunk_adder #(.WIDTH(3), .CHUNK(1)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
      .c_in(cin3), .sub(sub3), .out_valid(ov3), .out_ready(or3), .sum(s3),
      .c_out(co3), .ovf(of3)
   );

   exp_t q8[$];
   exp_t q3[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference for the 3-bit instance: plain integer arithmetic on the effective operands.
   function automatic exp_t ref3(input logic [2:0] a, input logic [2:0] b,
                                 input logic cin, input logic sub);
      logic [2:0] be;
      logic       ce;
      logic [3:0] t;
      exp_t       e;
      be  = sub ? ~b : b;
      ce  = sub ? ~cin : cin;
      t   = {1'b0, a} + {1'b0, be} + {3'b000, ce};
      e.s = {5'b00000, t[2:0]};
      e.c = t[3];
      e.v = (a[2] == be[2]) && (t[2] != a[2]);
      return e;
   endfunction

   // Scoreboard monitors: a handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (!rst && ov8 && or8) begin
         if (q8.size() == 0) chk("sb8_unexpected_result", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q8.pop_front();
            chk("sum8", {24'd0, s8}, {24'd0, e.s});
            chk("cout8", {31'd0, co8}, {31'd0, e.c});
            chk("ovf8", {31'd0, of8}, {31'd0, e.v});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov3 && or3) begin
         if (q3.size() == 0) chk("sb3_unexpected_result", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q3.pop_front();
            chk("sum3", {29'd0, s3}, {24'd0, e.s});
            chk("cout3", {31'd0, co3}, {31'd0, e.c});
            chk("ovf3", {31'd0, of3}, {31'd0, e.v});
         end
      end
   end

   // Inputs change 2 ns after a rising edge; outputs are sampled on the falling edge.
   task automatic op8(input vec_t v, input bit push);
      int n;
      n = 0;
      while (!ir8 && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      chk("ready8_wait", {31'd0, n < 50}, 32'd1);
      a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; iv8 = 1'b1;
      @(posedge clk);
      if (push) q8.push_back('{v.s, v.c, v.v});
      #2 iv8 = 1'b0;
   endtask

   task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic cin, input logic sub);
      int n;
      n = 0;
      while (!ir3 && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      chk("ready3_wait", {31'd0, n < 50}, 32'd1);
      a3 = a; b3 = b; cin3 = cin; sub3 = sub; iv3 = 1'b1;
      @(posedge clk);
      q3.push_back(ref3(a, b, cin, sub));
      #2 iv3 = 1'b0;
   endtask

   // Returns at a falling edge with out_valid high; lat = edges after accept.
   task automatic wait_out8(output int lat);
      lat = 0;
      while (lat < 50) begin
         @(negedge clk);
         if (ov8) break;
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic wait_out3(output int lat);
      lat = 0;
      while (lat < 50) begin
         @(negedge clk);
         if (ov3) break;
         @(posedge clk);
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[7];
      vec_t       v;
      int         lat;
      logic [7:0] hs;
      logic       hc, hv;

      tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[4] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
      tbl[5] = '{8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0};
      tbl[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

      #1 rst = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      chk("rst_state8", {27'd0, ir8, ov8, co8, of8, |s8}, 32'd0);
      chk("rst_state3", {27'd0, ir3, ov3, co3, of3, |s3}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_ready8", {31'd0, ir8}, 32'd1);
      chk("idle_ready3", {31'd0, ir3}, 32'd1);

      for (int i = 0; i < 7; i++) begin
         op8(tbl[i], 1'b1);
         wait_out8(lat);
         chk("latency8", lat, 32'd4);
         @(posedge clk); #2;
         chk("release8", {30'd0, ov8, ir8}, 32'd1);
      end

      // Backpressure: result must hold while out_ready is low; a new in_valid is ignored.
      or8 = 1'b0;
      v = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
      op8(v, 1'b1);
      wait_out8(lat);
      chk("latency8_bp", lat, 32'd4);
      hs = s8; hc = co8; hv = of8;
      chk("bp_value", {22'd0, hs, hc, hv}, {22'd0, 8'h46, 1'b0, 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         a8 = 8'hA0 + 8'(i); b8 = 8'h55; iv8 = 1'b1;
         chk("bp_hold", {20'd0, ov8, ir8, s8, co8, of8}, {20'd0, 1'b1, 1'b0, hs, hc, hv});
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      @(posedge clk); #2;
      chk("bp_release", {30'd0, ov8, ir8}, 32'd1);
      repeat (6) begin
         @(posedge clk); #2;
         chk("bp_no_stray", {31'd0, ov8}, 32'd0);
      end

      // Reset during the second BUSY cycle aborts the operation.
      v = '{8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
      op8(v, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_in_rst", {30'd0, ov8, ir8}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("abort_ready", {31'd0, ir8}, 32'd1);
      repeat (6) begin
         @(posedge clk); #2;
         chk("abort_no_valid", {31'd0, ov8}, 32'd0);
      end
      v = '{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
      op8(v, 1'b1);
      wait_out8(lat);
      chk("latency8_post_abort", lat, 32'd4);
      @(posedge clk); #2;
      chk("release8_post_abort", {30'd0, ov8, ir8}, 32'd1);

      // 3-bit instance, one bit per cycle.
      op3(3'd1, 3'd1, 1'b1, 1'b0);
      wait_out3(lat);
      chk("latency3", lat, 32'd3);
      @(posedge clk); #2;
      for (int i = 0; i < 8; i++) begin
         op3(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
             1'($urandom_range(1, 0)), (i >= 5) ? 1'($urandom_range(1, 0)) : 1'b0);
         wait_out3(lat);
         chk("latency3", lat, 32'd3);
         @(posedge clk); #2;
         chk("release3", {30'd0, ov3, ir3}, 32'd1);
      end

      repeat (3) @(posedge clk);
      chk("sb8_drained", q8.size(), 32'd0);
      chk("sb3_drained", q3.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/chunk_adder.md
# chunk_adder

Parametrised multi-cycle adder/subtractor and the successor to the team's 3-bit combinational adder. Operands of arbitrary WIDTH are processed CHUNK bits per cycle with a rippled carry register, so wide adds close timing at the core clock. Valid/ready handshakes on input and output let the block sit between the operand register file and the writeback stage of the CPU datapath. It adds subtract mode and a signed-overflow flag.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- CHUNK, 2, bits processed per cycle; WIDTH % CHUNK must be 0. NCH = WIDTH/CHUNK.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry in (add mode) or borrow in (sub mode).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out (add) or NOT-borrow (sub).
- ovf  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, BUSY, DONE. rst forces IDLE asynchronously.
- Reset values: in_ready 0 while rst is high, then 1 in IDLE. out_valid 0, sum 0, c_out 0, ovf 0, chunk index 0.
- IDLE: in_ready=1. If in_valid is high on an edge: latch a, the effective B (b if sub=0, ~b if sub=1) and the effective carry (c_in if sub=0, ~c_in if sub=1), clear the index, go to BUSY.
- Subtract computes a − b − c_in as a + ~b + ~c_in. c_out=1 means no borrow.
- BUSY: in_ready=0. Each edge adds chunk i (bits i·CHUNK+CHUNK−1 .. i·CHUNK) with the carry register, writes that chunk of sum, updates the carry and increments i. On the chunk with i = NCH−1: capture c_out, set ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, go to DONE.
- DONE: out_valid=1. sum, c_out and ovf are held stable. On an edge with out_ready=1, clear out_valid and go to IDLE. in_ready stays 0 in DONE; there is no overlap between results.
- Inputs a, b, c_in and sub are ignored outside the IDLE accept edge. Changing them during BUSY has no effect.
- sum is not guaranteed meaningful while out_valid=0. It must not be consumed then.
- CHUNK=WIDTH is legal: NCH=1 and one BUSY cycle.
- rst asserted in BUSY or DONE aborts the operation: out_valid drops immediately, the result is lost, the state returns to IDLE.

## Timing
- Accept edge T0, where in_valid and in_ready are both 1.
- Chunks are computed on edges T1..T_NCH. out_valid rises after edge T_NCH, so latency is NCH cycles from accept to out_valid.
- If out_ready is held at 1, the handshake completes on edge T_NCH+1. in_ready returns on the same edge, and the next accept is no earlier than T_NCH+2. Peak throughput is one operation per NCH+2 cycles.
- All outputs are registered except in_ready, which is decoded from the state and qualified with rst.

## Test plan
- WIDTH=8, CHUNK=2, add 0xFF+0x01, c_in=0 -> out_valid exactly 4 cycles after accept; sum=0x00, c_out=1, ovf=0.
- Add 0x7F+0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1. Add 0x80+0x80 -> sum=0x00, c_out=1, ovf=1.
- sub=1: 0x05−0x07, c_in=0 -> sum=0xFE, c_out=0, ovf=0. sub=1: 0x10−0x01, c_in=1 -> sum=0x0E, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, c_out and ovf stay stable; in_ready=0 throughout; a new in_valid is ignored; release -> IDLE on the next edge.
- WIDTH=3, CHUNK=1, a=1, b=1, c_in=1, then 5 random vectors -> sum = (a+b+c_in) mod 8 and c_out = bit 3, checked against a reference model.
- rst pulse on the 2nd BUSY cycle -> out_valid stays 0, in_ready=1 after rst deasserts; the next operation 0x03+0x04 -> 0x07 is correct.
